// File: rtl/rtc_secuenciador_transacciones.sv
`default_nettype none
// ============================================================================
// Module   : rtc_secuenciador_transacciones
// Brief    : Shares the RTC pulse generator between a periodic full-register
//            read and three user write functions (time, date, timer).
//            Arbitrates pending requests with fixed priority and steps the
//            generator through one byte transfer per RTC register.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_secuenciador_transacciones #(
  parameter int TICKS_LECTURA  = 1_000_000,
  parameter int CUENTA_FIN     = 24,
  parameter int CUENTA_CAPTURA = 16,
  parameter int N_LECTURA      = 9,
  parameter int N_ESCRITURA    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_hora,
  input  logic       req_fecha,
  input  logic       req_timer,
  output logic [1:0] funcion,
  output logic       en,
  output logic [4:0] cuenta,
  output logic [3:0] indice_registro,
  output logic       captura_dato,
  output logic       ocupado,
  output logic       fin_transaccion
);

  // Periodic counter width; kept at least one bit for degenerate settings
  localparam int c_TICK_W = (TICKS_LECTURA > 1) ? $clog2(TICKS_LECTURA) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICKS_LECTURA - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_UNO = c_TICK_W'(1);

  localparam logic [4:0] c_CUENTA_FIN = 5'(CUENTA_FIN);
  localparam logic [4:0] c_CUENTA_CAP = 5'(CUENTA_CAPTURA);
  localparam logic [3:0] c_ULT_LECT   = 4'(N_LECTURA - 1);
  localparam logic [3:0] c_ULT_ESCR   = 4'(N_ESCRITURA - 1);

  // Function codes seen by the pulse generator
  localparam logic [1:0] c_FN_LECTURA = 2'b00;
  localparam logic [1:0] c_FN_HORA    = 2'b01;
  localparam logic [1:0] c_FN_FECHA   = 2'b10;
  localparam logic [1:0] c_FN_TIMER   = 2'b11;

  typedef enum logic [1:0] {
    S_INACTIVO      = 2'd0,
    S_SELECCION     = 2'd1,
    S_TRANSFERENCIA = 2'd2,
    S_FIN           = 2'd3
  } estado_t;

  estado_t             r_estado;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                r_pend_hora;
  logic                r_pend_fecha;
  logic                r_pend_timer;
  logic                r_pend_lectura;
  logic [1:0]          r_funcion;
  logic                r_en;
  logic [4:0]          r_cuenta;
  logic [3:0]          r_indice;
  logic                r_captura;
  logic                r_ocupado;
  logic                r_fin;

  logic                w_tick_wrap;
  logic                w_alguno;
  logic [1:0]          w_ganador;
  logic                w_ultimo;

  assign w_tick_wrap = (r_tick_cnt == c_TICK_MAX);
  assign w_alguno    = r_pend_hora | r_pend_fecha | r_pend_timer | r_pend_lectura;
  // Last register of the running transaction depends on read vs. write
  assign w_ultimo    = (r_indice == ((r_funcion == c_FN_LECTURA) ? c_ULT_LECT : c_ULT_ESCR));

  // Free-running periodic read timer; keeps counting during transactions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick_wrap) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_UNO;
    end
  end

  // Pending flags: a request in the FIN cycle of its own function re-arms it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_hora    <= 1'b0;
      r_pend_fecha   <= 1'b0;
      r_pend_timer   <= 1'b0;
      r_pend_lectura <= 1'b1;
    end else begin
      r_pend_hora    <= req_hora    | (r_pend_hora    & ~(r_fin && (r_funcion == c_FN_HORA)));
      r_pend_fecha   <= req_fecha   | (r_pend_fecha   & ~(r_fin && (r_funcion == c_FN_FECHA)));
      r_pend_timer   <= req_timer   | (r_pend_timer   & ~(r_fin && (r_funcion == c_FN_TIMER)));
      r_pend_lectura <= w_tick_wrap | (r_pend_lectura & ~(r_fin && (r_funcion == c_FN_LECTURA)));
    end
  end

  // Fixed priority: hora > fecha > timer > periodic read
  always_comb begin
    w_ganador = c_FN_LECTURA;
    if (r_pend_hora) begin
      w_ganador = c_FN_HORA;
    end else if (r_pend_fecha) begin
      w_ganador = c_FN_FECHA;
    end else if (r_pend_timer) begin
      w_ganador = c_FN_TIMER;
    end
  end

  // Transaction sequencer; every generator-facing output is registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= S_INACTIVO;
      r_funcion <= c_FN_LECTURA;
      r_en      <= 1'b0;
      r_cuenta  <= 5'd0;
      r_indice  <= 4'd0;
      r_captura <= 1'b0;
      r_ocupado <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_captura <= 1'b0;
      r_fin     <= 1'b0;
      case (r_estado)
        S_INACTIVO: begin
          if (w_alguno) begin
            r_estado  <= S_SELECCION;
            r_ocupado <= 1'b1;
          end
        end
        S_SELECCION: begin
          r_funcion <= w_ganador;
          r_indice  <= 4'd0;
          r_cuenta  <= 5'd0;
          r_en      <= 1'b1;
          r_captura <= (w_ganador == c_FN_LECTURA) && (c_CUENTA_CAP == 5'd0);
          r_estado  <= S_TRANSFERENCIA;
        end
        S_TRANSFERENCIA: begin
          if (r_cuenta == c_CUENTA_FIN) begin
            r_cuenta <= 5'd0;
            if (w_ultimo) begin
              r_en     <= 1'b0;
              r_fin    <= 1'b1;
              r_estado <= S_FIN;
            end else begin
              r_indice  <= r_indice + 4'd1;
              r_captura <= (r_funcion == c_FN_LECTURA) && (c_CUENTA_CAP == 5'd0);
            end
          end else begin
            r_cuenta  <= r_cuenta + 5'd1;
            // Strobe lines up with the cycle in which cuenta shows the capture step
            r_captura <= (r_funcion == c_FN_LECTURA) && ((r_cuenta + 5'd1) == c_CUENTA_CAP);
          end
        end
        S_FIN: begin
          r_ocupado <= 1'b0;
          r_estado  <= S_INACTIVO;
        end
        default: begin
          r_estado <= S_INACTIVO;
        end
      endcase
    end
  end

  assign funcion         = r_funcion;
  assign en              = r_en;
  assign cuenta          = r_cuenta;
  assign indice_registro = r_indice;
  assign captura_dato    = r_captura;
  assign ocupado         = r_ocupado;
  assign fin_transaccion = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_rtc_secuenciador_transacciones.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_secuenciador_transacciones
// Brief    : Randomized scoreboard bench for the RTC transaction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_secuenciador_transacciones;

  localparam int T    = 600;
  localparam int CF   = 24;
  localparam int CC   = 16;
  localparam int NL   = 9;
  localparam int NE   = 3;
  localparam int BYTE = CF + 1;

  logic       clk;
  logic       reset_n;
  logic       req_hora;
  logic       req_fecha;
  logic       req_timer;
  logic [1:0] funcion;
  logic       en;
  logic [4:0] cuenta;
  logic [3:0] indice_registro;
  logic       captura_dato;
  logic       ocupado;
  logic       fin_transaccion;

  rtc_secuenciador_transacciones #(
    .TICKS_LECTURA (T),
    .CUENTA_FIN    (CF),
    .CUENTA_CAPTURA(CC),
    .N_LECTURA     (NL),
    .N_ESCRITURA   (NE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_hora       (req_hora),
    .req_fecha      (req_fecha),
    .req_timer      (req_timer),
    .funcion        (funcion),
    .en             (en),
    .cuenta         (cuenta),
    .indice_registro(indice_registro),
    .captura_dato   (captura_dato),
    .ocupado        (ocupado),
    .fin_transaccion(fin_transaccion)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         es_fin;
    logic [1:0] func;
    int         idx;
    int         ciclo;
    int         n_en;
  } evento_t;

  evento_t sb[$];
  int errores = 0;
  int checks  = 0;

  // Reference model: transaction-level view of arbitration and timing
  int cyc = 0;
  bit m_pend[4];          // 0 hora, 1 fecha, 2 timer, 3 periodic read
  bit m_busy;
  int m_t;
  int m_tcnt;
  int m_slot;
  int m_len;

  function automatic logic [1:0] codigo(input int slot);
    case (slot)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic m_reset();
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    m_pend[2] = 1'b0;
    m_pend[3] = 1'b1;
    m_busy    = 1'b0;
    m_t       = 0;
    m_tcnt    = 0;
    m_slot    = 3;
    m_len     = 0;
  endtask

  task automatic m_step();
    bit      wrap;
    bit      clr[4];
    evento_t e;
    for (int k = 0; k < 4; k++) clr[k] = 1'b0;
    wrap   = (m_tcnt == T - 1);
    m_tcnt = wrap ? 0 : m_tcnt + 1;
    if (!m_busy) begin
      if (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) begin
        m_busy = 1'b1;
        m_t    = 0;
      end
    end else begin
      m_t++;
      if (m_t == 1) begin
        m_slot = 3;
        for (int k = 3; k >= 0; k--) if (m_pend[k]) m_slot = k;
        m_len = ((m_slot == 3) ? NL : NE) * BYTE;
        if (m_slot == 3) begin
          for (int i = 0; i < NL; i++) begin
            e.es_fin = 1'b0; e.func = 2'b00; e.idx = i;
            e.ciclo  = cyc + i * BYTE + CC; e.n_en = 0;
            sb.push_back(e);
          end
        end
        e.es_fin = 1'b1; e.func = codigo(m_slot); e.idx = 0;
        e.ciclo  = cyc + m_len; e.n_en = m_len;
        sb.push_back(e);
      end else if (m_t == m_len + 2) begin
        clr[m_slot] = 1'b1;
        m_busy      = 1'b0;
      end
    end
    m_pend[0] = req_hora  | (m_pend[0] & ~clr[0]);
    m_pend[1] = req_fecha | (m_pend[1] & ~clr[1]);
    m_pend[2] = req_timer | (m_pend[2] & ~clr[2]);
    m_pend[3] = wrap      | (m_pend[3] & ~clr[3]);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_reset();
        sb.delete();
      end else begin
        m_step();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a capture or a finish
  int en_cnt = 0;
  initial begin
    evento_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        en_cnt = 0;
      end else begin
        if (en) en_cnt++;
        if (captura_dato || fin_transaccion) begin
          checks++;
          if (sb.size() == 0) begin
            errores++;
            $display("FAIL unexpected_event: captura=%0b fin=%0b funcion=%0d at cycle %0d, none required",
                     captura_dato, fin_transaccion, funcion, cyc);
          end else begin
            e = sb.pop_front();
            if (captura_dato) begin
              if (e.es_fin || fin_transaccion || indice_registro != 4'(e.idx) || cyc != e.ciclo ||
                  funcion != 2'b00 || cuenta != 5'(CC)) begin
                errores++;
                $display("FAIL captura: got idx=%0d cyc=%0d fn=%0d cuenta=%0d, required fin=%0b idx=%0d cyc=%0d fn=0 cuenta=%0d",
                         indice_registro, cyc, funcion, cuenta, e.es_fin, e.idx, e.ciclo, CC);
              end
            end else begin
              if (!e.es_fin || funcion != e.func || cyc != e.ciclo || en_cnt != e.n_en || en) begin
                errores++;
                $display("FAIL fin_transaccion: got fn=%0d cyc=%0d en_cycles=%0d en=%0b, required fin=%0b fn=%0d cyc=%0d en_cycles=%0d en=0",
                         funcion, cyc, en_cnt, en, e.es_fin, e.func, e.ciclo, e.n_en);
              end
              en_cnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errores++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_salidas_cero(input string pre);
    chk({pre, " funcion"}, int'(funcion), 0);
    chk({pre, " en"}, int'(en), 0);
    chk({pre, " cuenta"}, int'(cuenta), 0);
    chk({pre, " indice_registro"}, int'(indice_registro), 0);
    chk({pre, " captura_dato"}, int'(captura_dato), 0);
    chk({pre, " ocupado"}, int'(ocupado), 0);
    chk({pre, " fin_transaccion"}, int'(fin_transaccion), 0);
  endtask

  // Stimulus
  initial begin
    int  h[3];
    bit  found;
    reset_n   = 1'b0;
    req_hora  = 1'b0;
    req_fecha = 1'b0;
    req_timer = 1'b0;
    repeat (3) @(negedge clk);
    chk_salidas_cero("reset");
    reset_n = 1'b1;

    // Timer and hora both raised while the initial read runs
    repeat (50) @(negedge clk);
    req_timer = 1'b1;
    req_hora  = 1'b1;
    @(negedge clk);
    req_timer = 1'b0;
    req_hora  = 1'b0;

    // Random pulses and levels; long levels can straddle a FIN cycle
    for (int k = 0; k < 3; k++) h[k] = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (h[k] > 0) begin
          h[k]--;
        end else if ($urandom_range(0, 149) == 0) begin
          h[k] = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(1, 120));
        end
      end
      req_hora  = (h[0] > 0);
      req_fecha = (h[1] > 0);
      req_timer = (h[2] > 0);
    end
    req_hora  = 1'b0;
    req_fecha = 1'b0;
    req_timer = 1'b0;

    // Abort a write mid-byte with an asynchronous reset
    @(negedge clk);
    req_fecha = 1'b1;
    @(negedge clk);
    req_fecha = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (en && funcion != 2'b00 && indice_registro == 4'd1 && cuenta == 5'd10) found = 1'b1;
    end
    chk("wait_write_abort_point", int'(found), 1);
    reset_n = 1'b0;
    #1;
    chk_salidas_cero("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (fin_transaccion) found = 1'b1;
    end
    chk("post_reset_fin_seen", int'(found), 1);
    chk("post_reset_first_funcion", int'(funcion), 0);

    // Drain outstanding expectations
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_busy) found = 1'b1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_secuenciador_transacciones.md
# rtc_secuenciador_transacciones

Controller that sequences and shares the RTC pulse generator between a periodic full-register read and three user write requests (time, date, timer). It arbitrates pending requests, drives the generator's `funcion`, `en` and 5-bit `cuenta` inputs through one byte transfer per RTC register, and flags when read data is valid. It sits between the programming/UI logic and the RTC pulse-generation logic.

## Interface

- `TICKS_LECTURA`, default 1_000_000: clock cycles between periodic full reads; counter width is `$clog2(TICKS_LECTURA)`.
- `CUENTA_FIN`, default 24: last `cuenta` value of one byte transfer; legal range 1..31.
- `CUENTA_CAPTURA`, default 16: `cuenta` value at which read data is valid on the RTC bus.
- `N_LECTURA`, default 9: registers per full read (seg, min, hora, dia, mes, año, timer seg/min/hora).
- `N_ESCRITURA`, default 3: registers per write function.

- `clk`, in, 1: system clock; one clock domain.
- `reset_n`, in, 1: asynchronous active-low reset.
- `req_hora`, in, 1: request to write time registers; pulse or level.
- `req_fecha`, in, 1: request to write date registers.
- `req_timer`, in, 1: request to write timer registers.
- `funcion`, out, 2: to the pulse generator; 00 full read, 01 write time, 10 write date, 11 write timer.
- `en`, out, 1: pulse generator enable; high only while a byte transfer is running.
- `cuenta`, out, 5: transfer step counter to the pulse generator.
- `indice_registro`, out, 4: register index within the current transaction, 0-based.
- `captura_dato`, out, 1: one-cycle strobe; the read byte for `indice_registro` is valid.
- `ocupado`, out, 1: transaction in progress.
- `fin_transaccion`, out, 1: one-cycle pulse when a transaction completes.

## Operation

- Pending flags `pend_hora`, `pend_fecha`, `pend_timer`, `pend_lectura` are registered. Each `req_*` sampled high sets its flag. The flag clears in the cycle `fin_transaccion` is asserted for that function. A request that is high in that same cycle re-sets the flag, so one more transaction follows.
- Periodic counter runs free from 0 to `TICKS_LECTURA-1`, then wraps. On wrap it sets `pend_lectura`; the flag is idempotent when already set. The counter keeps running during transactions.
- `pend_lectura` resets to 1, so the first transaction after reset is a full read.
- Fixed priority: hora > fecha > timer > lectura. A lower-priority request is never lost, only delayed.
- FSM states:
  - INACTIVO: when any flag is set, go to SELECCION.
  - SELECCION: latch the winner into `funcion`; `indice_registro`=0; `cuenta`=0; go to TRANSFERENCIA.
  - TRANSFERENCIA: `en`=1 and `cuenta` increments each cycle. At `cuenta`=`CUENTA_FIN`:
    - if `indice_registro` = N−1 (N is `N_LECTURA` for 00, `N_ESCRITURA` otherwise), go to FIN;
    - else `indice_registro`+1, `cuenta`←0 and stay in TRANSFERENCIA.
  - FIN: `en`=0, `fin_transaccion`=1, clear the served flag, go to INACTIVO.
- `captura_dato` = TRANSFERENCIA ∧ `funcion`=00 ∧ `cuenta`=`CUENTA_CAPTURA`. It is never asserted on writes.
- `funcion` holds its value outside a transaction; the generator ignores it while `en`=0.
- `ocupado` is high in SELECCION, TRANSFERENCIA and FIN.

## Timing

- Reset values: `funcion`=00, `en`=0, `cuenta`=0, `indice_registro`=0, `captura_dato`=0, `ocupado`=0, `fin_transaccion`=0. The FSM is in INACTIVO, the periodic counter is 0 and `pend_lectura` is 1.
- Asserting `reset_n` mid-transaction forces all outputs to their reset values immediately, without waiting for a clock edge. Partial transfers are abandoned and write flags are cleared.
- Latency, from `req_*` sampled high at edge k with the FSM idle:
  - flag set at k;
  - SELECCION at k+1;
  - `en`=1 with `cuenta`=0 at k+2.
- Byte transfer: `CUENTA_FIN`+1 cycles, with no gap between consecutive bytes.
- Write transaction: 3×25 = 75 cycles of `en`.
- Full read: 9×25 = 225 cycles of `en` and exactly 9 `captura_dato` strobes.
- `fin_transaccion` is high in the cycle immediately after the last `cuenta`=`CUENTA_FIN` cycle.
- Back-to-back transactions: FIN → INACTIVO → SELECCION gives exactly 3 idle-`en` cycles between transactions.

## Test plan

- Reset release with no requests → full read starts (`funcion`=00, `en` at cycle 2 after reset release, since `pend_lectura`=1 at reset) → 9 `captura_dato` strobes with `indice_registro` 0..8, each at `cuenta`=16 → `fin_transaccion` after 225 `en` cycles.
- Single-cycle `req_fecha` pulse while idle → `funcion`=10, `en` at k+2, 75 `en` cycles, `indice_registro` 0..2, no `captura_dato`, one `fin_transaccion`.
- `req_timer`, `req_hora` and a periodic tick all pending at once → served in order 01, 11, 00, with 3 idle cycles between transactions.
- `req_hora` held high through its own FIN cycle → a second 01 transaction follows; `req_hora` dropped before FIN → exactly one transaction.
- `TICKS_LECTURA`=50 with `req_hora` during a read → read completes uninterrupted; the hora write follows; the tick during the write sets `pend_lectura` once only.
- `reset_n` low at `cuenta`=10, `indice_registro`=1 of a write → all outputs 0 immediately; after release the next transaction is a full read, not the aborted write.
